// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: round-robin arbiter that turns one requester transaction
// at a time into the RAM's two-word command sequence (address word, then
// data word) and collects read data back from the RAM.
//
// Requester handshake: a requester raises req[i] with we/addr/wdata stable
// and holds it until it sees done[i]. gnt[i] pulses for one cycle when its
// request is captured; from then on the captured copy is used, so req/we/
// addr/wdata may change freely. done[i] pulses once per captured request,
// together with err on a read timeout. The arbiter revisits IDLE for one
// cycle after every done, so a req still high in the done cycle is granted
// again.
module ram_cmd_arbiter #(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ-1:0]            we,
   input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [N_REQ*ADDR_WIDTH-1:0] wdata,
   output logic [N_REQ-1:0]            gnt,
   output logic [N_REQ-1:0]            done,
   output logic                        err,
   output logic [ADDR_WIDTH-1:0]       rdata,
   output logic [ADDR_WIDTH+1:0]       ram_din,
   output logic                        ram_rx_valid,
   input  logic [ADDR_WIDTH-1:0]       ram_dout,
   input  logic                        ram_tx_valid,
   output logic                        busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ADDR    = 2'd1,
      S_DATA    = 2'd2,
      S_WAIT_RD = 2'd3
   } state_t;

   // state and ptr are kept as plainly named signals so checkers can bind to them
   state_t                  state;
   logic [IDX_W-1:0]        ptr;
   logic [IDX_W-1:0]        cur_idx;
   logic                    cur_we;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [ADDR_WIDTH-1:0]   cur_wdata;
   logic [7:0]              timer;

   logic                    pick_found;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_we;
   logic [ADDR_WIDTH-1:0]   pick_addr;
   logic [ADDR_WIDTH-1:0]   pick_wdata;
   logic [IDX_W-1:0]        next_ptr;
   logic [N_REQ-1:0]        pick_onehot;
   logic [N_REQ-1:0]        cur_onehot;

   // Round-robin pick: first set req at index >= ptr, wrapping; scanning from
   // the far end down lets the nearest candidate win.
   always_comb begin
      int j;
      j          = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_we    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N_REQ;
         if (req[j]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(j);
            pick_we    = we[j];
            pick_addr  = addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            pick_wdata = wdata[j*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   assign next_ptr    = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
   assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
   assign cur_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << cur_idx;

   // Transaction FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         ptr          <= '0;
         cur_idx      <= '0;
         cur_we       <= 1'b0;
         cur_addr     <= '0;
         cur_wdata    <= '0;
         timer        <= '0;
         gnt          <= '0;
         done         <= '0;
         err          <= 1'b0;
         rdata        <= '0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         gnt  <= '0;
         done <= '0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               ram_rx_valid <= 1'b0;
               if (pick_found) begin
                  cur_idx   <= pick_idx;
                  cur_we    <= pick_we;
                  cur_addr  <= pick_addr;
                  cur_wdata <= pick_wdata;
                  gnt       <= pick_onehot;
                  ptr       <= next_ptr;
                  busy      <= 1'b1;
                  state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               ram_rx_valid <= 1'b1;
               ram_din      <= {(cur_we ? 2'b00 : 2'b10), cur_addr};
               state        <= S_DATA;
            end
            S_DATA: begin
               ram_rx_valid <= 1'b1;
               if (cur_we) begin
                  ram_din <= {2'b01, cur_wdata};
                  done    <= cur_onehot;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  ram_din <= {2'b11, {ADDR_WIDTH{1'b0}}};
                  timer   <= '0;
                  state   <= S_WAIT_RD;
               end
            end
            S_WAIT_RD: begin
               ram_rx_valid <= 1'b0;
               if (ram_tx_valid) begin
                  rdata <= ram_dout;
                  done  <= cur_onehot;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (timer == 8'(TIMEOUT)) begin
                  done  <= cur_onehot;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Testbench for ram_cmd_arbiter: directed transactions push cycle-stamped
// expected gnt / command-word / done records into queues; a negedge monitor
// pops and compares whenever the DUT presents one of those outputs.
module tb_ram_cmd_arbiter;

   localparam int N  = 2;
   localparam int AW = 8;
   localparam int TO = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [N-1:0]      we;
   logic [N*AW-1:0]   addr;
   logic [N*AW-1:0]   wdata;
   logic [N-1:0]      gnt;
   logic [N-1:0]      done;
   logic              err;
   logic [AW-1:0]     rdata;
   logic [AW+1:0]     ram_din;
   logic              ram_rx_valid;
   logic [AW-1:0]     ram_dout;
   logic              ram_tx_valid;
   logic              busy;

   ram_cmd_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .done(done), .err(err), .rdata(rdata), .ram_din(ram_din),
      .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
      .ram_tx_valid(ram_tx_valid), .busy(busy)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: entries are {cycle[15:0], value[15:0]}
   logic [31:0] gnt_q[$];
   logic [31:0] cmd_q[$];
   logic [31:0] done_q[$];
   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] pk(input int c, input logic [15:0] v);
      logic [31:0] cc;
      cc = c;
      return {cc[15:0], v};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] got);
      total++;
      bad++;
      $display("FAIL %s got=%h want=<nothing> (t=%0t)", name, got, $time);
   endtask

   // monitor
   logic [31:0] e_g, e_c, e_d;
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != '0) begin
            if (gnt_q.size() == 0) unexpected("unexpected_gnt", pk(cyc, {14'b0, gnt}));
            else begin
               e_g = gnt_q.pop_front();
               check("gnt", pk(cyc, {14'b0, gnt}), e_g);
            end
         end
         if (ram_rx_valid) begin
            if (cmd_q.size() == 0) unexpected("unexpected_cmd", pk(cyc, {6'b0, ram_din}));
            else begin
               e_c = cmd_q.pop_front();
               check("cmd", pk(cyc, {6'b0, ram_din}), e_c);
            end
         end
         if (done != '0 || err) begin
            if (done_q.size() == 0) unexpected("unexpected_done", pk(cyc, {5'b0, err, done, rdata}));
            else begin
               e_d = done_q.pop_front();
               check("done", pk(cyc, {5'b0, err, done, rdata}), e_d);
            end
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
      req[i]             = 1'b1;
      we[i]              = w;
      addr[i*AW +: AW]   = a;
      wdata[i*AW +: AW]  = d;
   endtask

   int t;

   initial begin
      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
      ram_dout = '0; ram_tx_valid = 1'b0;
      #1;
      check("rst_gnt",   {30'b0, gnt}, 32'h0);
      check("rst_done",  {30'b0, done}, 32'h0);
      check("rst_err",   {31'b0, err}, 32'h0);
      check("rst_rdata", {24'b0, rdata}, 32'h0);
      check("rst_din",   {22'b0, ram_din}, 32'h0);
      check("rst_rxv",   {31'b0, ram_rx_valid}, 32'h0);
      check("rst_busy",  {31'b0, busy}, 32'h0);
      tick(2);
      rst = 1'b0;
      tick(1);

      // single write from requester 0
      t = cyc + 1;
      set_req(0, 1'b1, 8'h3C, 8'hA5);
      gnt_q.push_back(pk(t, 16'h0001));
      cmd_q.push_back(pk(t + 1, 16'h003C));
      cmd_q.push_back(pk(t + 2, 16'h01A5));
      done_q.push_back(pk(t + 2, 16'h0100));
      tick(1);
      check("write_busy", {31'b0, busy}, 32'h1);
      tick(2);
      check("write_busy_end", {31'b0, busy}, 32'h0);
      req[0] = 1'b0;
      tick(2);

      // single read from requester 1, RAM answers 2 cycles after READ_DATA word
      t = cyc + 1;
      set_req(1, 1'b0, 8'h3C, 8'h00);
      gnt_q.push_back(pk(t, 16'h0002));
      cmd_q.push_back(pk(t + 1, 16'h023C));
      cmd_q.push_back(pk(t + 2, 16'h0300));
      done_q.push_back(pk(t + 5, 16'h02A5));
      tick(5);
      ram_tx_valid = 1'b1; ram_dout = 8'hA5;
      tick(1);
      ram_tx_valid = 1'b0; ram_dout = 8'h00;
      req[1] = 1'b0;
      tick(2);
      check("read_rdata", {24'b0, rdata}, 32'h0000_00A5);

      // read timeout from requester 0
      t = cyc + 1;
      set_req(0, 1'b0, 8'h55, 8'h00);
      gnt_q.push_back(pk(t, 16'h0001));
      cmd_q.push_back(pk(t + 1, 16'h0255));
      cmd_q.push_back(pk(t + 2, 16'h0300));
      done_q.push_back(pk(t + 3 + TO, 16'h05A5));
      tick(TO + 4);
      check("timeout_err", {31'b0, err}, 32'h1);
      req[0] = 1'b0;
      tick(2);

      // stray ram_tx_valid in IDLE and in ADDR
      tick(1);
      ram_tx_valid = 1'b1; ram_dout = 8'hEE;
      tick(1);
      ram_tx_valid = 1'b0;
      tick(1);
      t = cyc + 1;
      set_req(1, 1'b1, 8'h10, 8'h77);
      gnt_q.push_back(pk(t, 16'h0002));
      cmd_q.push_back(pk(t + 1, 16'h0010));
      cmd_q.push_back(pk(t + 2, 16'h0177));
      done_q.push_back(pk(t + 2, 16'h02A5));
      tick(1);
      ram_tx_valid = 1'b1; ram_dout = 8'hEE;
      tick(1);
      ram_tx_valid = 1'b0; ram_dout = 8'h00;
      tick(1);
      req[1] = 1'b0;
      tick(2);
      check("stray_rdata", {24'b0, rdata}, 32'h0000_00A5);

      // reset in the middle of a write's DATA phase
      t = cyc + 1;
      set_req(0, 1'b1, 8'h66, 8'h99);
      gnt_q.push_back(pk(t, 16'h0001));
      cmd_q.push_back(pk(t + 1, 16'h0066));
      tick(2);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_rxv",   {31'b0, ram_rx_valid}, 32'h0);
      check("midrst_busy",  {31'b0, busy}, 32'h0);
      check("midrst_gnt",   {30'b0, gnt}, 32'h0);
      check("midrst_done",  {30'b0, done}, 32'h0);
      check("midrst_din",   {22'b0, ram_din}, 32'h0);
      check("midrst_rdata", {24'b0, rdata}, 32'h0);
      req = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(2);

      // round-robin with both requesters held, all writes; ptr restarts at 0
      set_req(0, 1'b1, 8'h11, 8'h22);
      set_req(1, 1'b1, 8'h33, 8'h44);
      t = cyc + 1;
      for (int n = 0; n < 4; n++) begin
         int tn;
         tn = t + 3 * n;
         if (n % 2 == 0) begin
            gnt_q.push_back(pk(tn, 16'h0001));
            cmd_q.push_back(pk(tn + 1, 16'h0011));
            cmd_q.push_back(pk(tn + 2, 16'h0122));
            done_q.push_back(pk(tn + 2, 16'h0100));
         end else begin
            gnt_q.push_back(pk(tn, 16'h0002));
            cmd_q.push_back(pk(tn + 1, 16'h0033));
            cmd_q.push_back(pk(tn + 2, 16'h0144));
            done_q.push_back(pk(tn + 2, 16'h0200));
         end
      end
      tick(10);
      req = '0;
      tick(6);

      check("gnt_q_empty",  gnt_q.size(), 32'h0);
      check("cmd_q_empty",  cmd_q.size(), 32'h0);
      check("done_q_empty", done_q.size(), 32'h0);
      check("final_busy", {31'b0, busy}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Shares the single-port RAM between N_REQ requesters (SPI slave path plus on-chip masters).
- Each granted transaction becomes the RAM's two-word command sequence on ram_din/ram_rx_valid:
  - address word, then data word
  - din[9:8] = 00 WRITE_ADDR, 01 WRITE_DATA, 10 READ_ADDR, 11 READ_DATA
- Collects read data from ram_dout/ram_tx_valid.
- Arbitration is round-robin, one transaction in flight at a time.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 8, RAM address width; also data width of the command payload
- TIMEOUT, 15, max cycles in WAIT_RD for ram_tx_valid before err (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  request per requester; held until that requester's done or err pulse
- we  in  N_REQ  1=write, 0=read; sampled at grant
- addr  in  N_REQ*ADDR_WIDTH  flattened; requester i at [i*AW +: AW]
- wdata  in  N_REQ*ADDR_WIDTH  flattened write data
- gnt  out  N_REQ  one-hot, 1-cycle pulse when request is captured
- done  out  N_REQ  one-hot, 1-cycle pulse on completion
- err  out  1  1-cycle pulse, read timeout; coincides with done of that requester
- rdata  out  ADDR_WIDTH  read data, valid with done for a read
- ram_din  out  ADDR_WIDTH+2  command word to RAM
- ram_rx_valid  out  1  command word valid
- ram_dout  in  ADDR_WIDTH  RAM read data
- ram_tx_valid  in  1  RAM read data valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: gnt=0, done=0, err=0, rdata=0, ram_din=0, ram_rx_valid=0, busy=0, rr pointer=0, state=IDLE.
- All outputs are registered.
- FSM: IDLE -> ADDR -> DATA -> (write: IDLE) | (read: WAIT_RD -> IDLE).
- IDLE:
  - if any req, choose the first set bit at index >= ptr, wrapping modulo N_REQ.
  - Latch index, we, addr, wdata; pulse gnt[idx]; ptr <= idx+1 (wrap); go to ADDR.
- ADDR:
  - ram_rx_valid=1, ram_din={we?2'b00:2'b10, addr}; go to DATA.
- DATA:
  - ram_rx_valid=1.
  - Write: ram_din={2'b01, wdata}; pulse done[idx]; go to IDLE.
  - Read: ram_din={2'b11, {AW{1'b0}}}; clear timer; go to WAIT_RD.
- WAIT_RD:
  - ram_rx_valid=0; timer increments each cycle.
  - If ram_tx_valid: rdata<=ram_dout, pulse done[idx], go to IDLE.
  - Else if timer==TIMEOUT: pulse done[idx] and err, rdata unchanged, go to IDLE.
- ram_rx_valid is 0 in IDLE and WAIT_RD.
- ram_din holds its last value when ram_rx_valid=0.
- Latency:
  - write: gnt at cycle T, address word at T+1, data word at T+2, done at T+2.
  - read: done one cycle after ram_tx_valid is sampled high.
- Back-to-back: IDLE is always visited for one cycle, so the next gnt is at earliest cycle done+1.
- ram_tx_valid outside WAIT_RD is ignored.
- A requester dropping req after gnt has no effect; the captured transaction completes.
- Requests in non-IDLE states wait; no grant while busy.
- Simultaneous requests: round-robin guarantees each requester a grant within N_REQ transactions.
- rst asserted mid-transaction: all outputs and state return to reset values immediately. Any half-issued command pair is abandoned; the RAM side is reset by the same rst.

Test Plan:
- Reset: assert rst mid-DATA of a write -> same cycle ram_rx_valid=0, busy=0, gnt/done=0; after release ptr=0.
- Single write: req[0], we=1, addr=8'h3C, wdata=8'hA5 -> gnt[0] at T; ram_din=10'h03C at T+1; ram_din=10'h1A5 with done[0] at T+2; ram_rx_valid high exactly 2 cycles.
- Single read:
  - Stimulus: req[1], addr=8'h3C; RAM model returns 8'hA5 with ram_tx_valid 2 cycles after the 11-word.
  - Response: ram_din=10'h23C, then 10'h300; rdata=8'hA5 with done[1]; err=0.
- Read timeout: RAM model never raises ram_tx_valid -> done[0] and err pulse together exactly TIMEOUT+1 cycles after the READ_DATA word; rdata unchanged.
- Round-robin: req=2'b11 held continuously, all writes -> grants alternate gnt[0], gnt[1], gnt[0], ...; 3 cycles per transaction; no requester granted twice in a row.
- Stray tx_valid: pulse ram_tx_valid in IDLE and during ADDR -> no done, rdata unchanged.
